// File: rtl/inst_buffer.sv
// Instruction buffer between IF and ID: a DEPTH-entry FIFO with taken-branch truncation and flush.
// Define IBUF_BR_PAIR_EN to hold a branch at the head until its delay slot is buffered.
module inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs_valid,
  input  logic [DATA_W-1:0]          fs_data,
  input  logic                       fs_is_br,
  output logic                       fs_allowin,
  output logic                       ds_valid,
  output logic [DATA_W-1:0]          ds_data,
  output logic                       ds_is_br,
  input  logic                       ds_allowin,
  input  logic                       ds_br_taken,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_br   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              hold;
  logic              enq;
  logic              deq;
  logic              trunc;
  logic              wr_en;

  assign fs_allowin = (count != CNT_W'(DEPTH));
  assign ds_data    = mem_data[rd_ptr];
  assign ds_is_br   = mem_br[rd_ptr];

`ifdef IBUF_BR_PAIR_EN
  // A lone branch at the head stays hidden until its delay slot arrives.
  assign hold = ds_is_br & (count == CNT_W'(1));
`else
  assign hold = 1'b0;
`endif

  assign ds_valid = (count != '0) & ~hold;
  assign enq      = fs_valid & fs_allowin;
  assign deq      = ds_valid & ds_allowin;
  // With a single entry the normal path already keeps a same-cycle delay slot.
  assign trunc    = deq & ds_br_taken & (count >= CNT_W'(2));
  assign wr_en    = enq & ~flush & ~trunc;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= fs_data;
      mem_br[wr_ptr]   <= fs_is_br;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (trunc) begin
      // Keep only the delay slot; younger wrong-path entries are dropped.
      rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= rd_ptr + PTR_W'(2);
      count  <= CNT_W'(1);
    end else begin
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios then random traffic against a queue model.
module tb_inst_buffer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef IBUF_BR_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              fs_valid;
  logic [DATA_W-1:0] fs_data;
  logic              fs_is_br;
  logic              fs_allowin;
  logic              ds_valid;
  logic [DATA_W-1:0] ds_data;
  logic              ds_is_br;
  logic              ds_allowin;
  logic              ds_br_taken;
  logic              flush;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .fs_valid(fs_valid), .fs_data(fs_data), .fs_is_br(fs_is_br), .fs_allowin(fs_allowin),
    .ds_valid(ds_valid), .ds_data(ds_data), .ds_is_br(ds_is_br), .ds_allowin(ds_allowin),
    .ds_br_taken(ds_br_taken), .flush(flush), .count(count)
  );

  typedef struct packed {
    logic              br;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic bit m_valid();
    return (q.size() != 0) && !(PAIR && q[0].br && (q.size() == 1));
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fs_allowin"}, DATA_W'(fs_allowin), DATA_W'(q.size() != DEPTH));
    chk({tag, ".ds_valid"}, DATA_W'(ds_valid), DATA_W'(m_valid()));
    chk({tag, ".count"}, DATA_W'(count), DATA_W'(q.size()));
    if (m_valid()) begin
      chk({tag, ".ds_data"}, ds_data, q[0].d);
      chk({tag, ".ds_is_br"}, DATA_W'(ds_is_br), DATA_W'(q[0].br));
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic br,
                       input logic ai, input logic tk, input logic fl);
    fs_valid = v; fs_data = d; fs_is_br = br;
    ds_allowin = ai; ds_br_taken = tk; flush = fl;
  endtask

  // Model advances on the edge using the inputs held across it.
  task automatic tick();
    bit   v, enq, deq, tk, fl, rst_act;
    ent_t e, ds;
    v   = m_valid();
    enq = fs_valid && (q.size() != DEPTH);
    deq = v && ds_allowin;
    tk  = ds_br_taken;
    fl  = flush;
    e   = '{fs_is_br, fs_data};
    @(posedge clk);
    rst_act = !resetn;
    if (rst_act) q.delete();
    else if (fl) q.delete();
    else if (deq && tk && q.size() >= 2) begin
      ds = q[1];
      q.delete();
      q.push_back(ds);
    end else begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
    end
    #1;
  endtask

  task automatic step(input string tag);
    check_all(tag);
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_all("reset");
    resetn = 1'b1;
    tick();

    // Fill with ID stalled: A..E offered, E refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DATA_W'(64'hA + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step("fill");
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("full");
    chk("full.count4", DATA_W'(count), DATA_W'(4));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", ds_data, DATA_W'(64'hA + i));
      step("drain");
    end
    check_all("drained");

    // Wrap: streaming with ID always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DATA_W'(64'h100 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      step("wrap");
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wrap_end");

    // Branch followed later by its delay slot, ID stalled.
    drive(1'b1, DATA_W'(64'hB0), 1'b1, 1'b0, 1'b0, 1'b0);
    step("pair_x");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pair_idle");
    drive(1'b1, DATA_W'(64'hB1), 1'b0, 1'b0, 1'b0, 1'b0);
    step("pair_y");
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pair_drain");

    // Truncation: [BR, DS, W1, W2], taken branch with same-cycle offer W3.
    drive(1'b1, DATA_W'(64'hC0), 1'b1, 1'b0, 1'b0, 1'b0);
    step("tr_fill");
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, DATA_W'(64'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step("tr_fill");
    end
    drive(1'b1, DATA_W'(64'hC4), 1'b0, 1'b1, 1'b1, 1'b0);
    step("tr_take");
    chk("tr.count1", DATA_W'(count), DATA_W'(1));
    chk("tr.head_ds", ds_data, DATA_W'(64'hC1));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("tr_drain");

    // Flush with simultaneous enqueue and dequeue.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(64'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step("fl_fill");
    end
    drive(1'b1, DATA_W'(64'hDF), 1'b0, 1'b1, 1'b0, 1'b1);
    step("flush");
    chk("flush.count0", DATA_W'(count), DATA_W'(0));
    chk("flush.valid0", DATA_W'(ds_valid), DATA_W'(0));
    chk("flush.allowin", DATA_W'(fs_allowin), DATA_W'(1));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with two entries buffered.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DATA_W'(64'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step("ar_fill");
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar.count2", DATA_W'(count), DATA_W'(2));
    #2 resetn = 1'b0;
    #1;
    chk("ar.valid_async", DATA_W'(ds_valid), DATA_W'(0));
    chk("ar.count_async", DATA_W'(count), DATA_W'(0));
    q.delete();
    #3 resetn = 1'b1;
    tick();
    check_all("ar_release");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic tk;
      tk = m_valid() && q[0].br && ($urandom_range(1) == 1);
      drive($urandom_range(3) != 0, {$urandom, $urandom}, $urandom_range(3) == 0,
            $urandom_range(2) != 0, tk, $urandom_range(31) == 0);
      step("rand");
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("rand_drain");
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised instruction buffer between IF and ID. It decouples fetch from decode with a DEPTH-entry FIFO that replaces the single `fs_to_ds_bus_r` capture register of the ID stage. It adds two behaviours: it holds a branch at the head until its delay slot is buffered, and it discards wrong-path entries younger than the delay slot when ID resolves a branch as taken. Pipeline flush (eret or exception) empties it.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `DATA_W`, 64, opaque payload width (pc, inst and exception sideband packed by IF).

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `fs_valid` in 1: IF offers an entry.
- `fs_data` in DATA_W: payload.
- `fs_is_br` in 1: entry is a branch or jump (IF predecode).
- `fs_allowin` out 1: buffer accepts the entry this cycle.
- `ds_valid` out 1: head entry is presented to ID.
- `ds_data` out DATA_W: head payload.
- `ds_is_br` out 1: head is a branch.
- `ds_allowin` in 1: ID consumes the head this cycle.
- `ds_br_taken` in 1: the head being consumed is a taken branch. Only meaningful with `ds_valid & ds_allowin & ds_is_br`.
- `flush` in 1: pipeline flush (eret | ex).
- `count` out $clog2(DEPTH+1): occupancy.

## Operation
- Storage: circular array with `rd_ptr` and `wr_ptr` of $clog2(DEPTH) bits, plus `count`. Pointers wrap modulo DEPTH.
- Enqueue fires on `enq = fs_valid & fs_allowin`. Dequeue fires on `deq = ds_valid & ds_allowin`.
- `fs_allowin = (count != DEPTH)`. It comes from registered state only and does not depend on `ds_allowin`.
- `ds_valid = (count != 0) & !hold`. `ds_data` and `ds_is_br` come from `mem[rd_ptr]`.
- Branch pairing (see Configuration): `hold = ds_is_br_head & (count == 1)`. The branch stays invisible to ID until its delay slot is present.
- Normal cycle: write on `enq`, advance `rd_ptr` on `deq`. `count += enq - deq`.
- Taken-branch truncation (`deq & ds_br_taken`):
  - count ≥ 2: the delay slot is at `rd_ptr+1`. Set `wr_ptr = rd_ptr+2` and `count = 1`. Any same-cycle enqueue is discarded (accepted, then dropped).
  - count == 1: only possible with pairing disabled. The same-cycle enqueue, if any, is the delay slot and is stored; `count = enq`.
- IF is responsible for cancelling its own in-flight wrong-path fetches after redirect. This block drops only buffered entries.
- `flush`: `rd_ptr = wr_ptr = 0`, `count = 0`. The same-cycle enqueue, dequeue and truncation are ignored.
- Priority: reset > flush > truncation > normal.

## Timing
- Reset values: `count = 0`, pointers 0, `ds_valid = 0`, `fs_allowin = 1`. `ds_data` and `ds_is_br` are don't-care while `ds_valid = 0`.
- Enqueue-to-visible latency: 1 cycle. There is no combinational fs→ds bypass.
- Throughput: 1 enqueue and 1 dequeue per cycle.
- Full: `fs_allowin = 0` even if ID dequeues in the same cycle. The freed slot is usable the next cycle.
- Empty: `ds_valid = 0`. An enqueue into an empty buffer is visible the next cycle.
- Flush is asserted for one cycle. The buffer is empty and `fs_allowin = 1` in the following cycle.
- Asynchronous reset mid-operation drops all entries immediately. Outputs reach their reset values without waiting for a clock edge.

## Configuration
- `IBUF_BR_PAIR_EN` defined:
  - `hold` is active as described.
  - ID never sees a branch without its delay slot buffered, so the count==1 truncation path is unreachable.
- Not defined:
  - `hold = 0`; a branch is presented as soon as it is buffered.
  - The count==1 truncation path is live.
  - ID must tolerate a missing delay slot.

## Test plan
- Fill from reset with DEPTH=4, ID stalled, 5 offered entries A–E:
  - `fs_allowin` drops after D; `count = 4`.
  - Release ID: A, B, C, D come out in order over 4 cycles, one per cycle.
- Wrap: stream 10 entries with `ds_allowin = 1` throughout → output order matches input order; `count` never exceeds 1.
- Pairing (macro on): enqueue branch X, then idle 3 cycles, then delay slot Y.
  - `ds_valid = 0` while only X is buffered.
  - X becomes visible the cycle after Y is written.
- Truncation: buffer holds [BR, DS, W1, W2]; dequeue BR with `ds_br_taken = 1` and a same-cycle enqueue W3.
  - Next cycle `count = 1` and head = DS.
  - W1, W2 and W3 never appear.
- Flush: `count = 3`, assert `flush` together with `fs_valid = 1` and `ds_allowin = 1` → next cycle `count = 0` and `ds_valid = 0`.
- Async reset: deassert `resetn` between clock edges with `count = 2` → `ds_valid` falls without a clock edge; after release, `count = 0`.
